ext_serial_link: RTL
====================

Name: ext_serial_link

Overview:
- Parametrised successor to the single-byte external TX/RX interface.
- Half-duplex, auto-baud serial link layer with per-frame acknowledge, configurable data width, TX/RX FIFOs, ack timeout with retry, and error flags.
- Sits between the board-level tx/rx pins and the bus master/slave glue logic, which uses only the valid/ready FIFO ports.

Parameters:
- DATA_WIDTH, 10: bits per frame payload, LSB first.
- FIFO_DEPTH, 4: entries per TX and RX FIFO; power of 2, at least 2.
- BAUD_W, 16: width of the baud counter and the measured baud size.
- DEFAULT_BAUD, 8: clocks per bit after reset when AUTOBAUD=0.
- AUTOBAUD, 1: 1 = first low pulse after reset or relock is a calibration pulse.
- ACK_TIMEOUT, 4: bit-times to wait for ack after a transmitted stop bit.
- MAX_RETRY, 2: retransmissions before a frame is dropped.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  serial input, idle high; already synchronised upstream.
- tx  out  1  serial output, idle high.
- tx_data  in  DATA_WIDTH  frame to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  DATA_WIDTH  head of RX FIFO.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  consumer pops the RX FIFO.
- relock  in  1  pulse: discard baud lock and recalibrate.
- baud_locked  out  1  baud_size is valid.
- baud_size  out  BAUD_W  current clocks per bit.
- tx_err  out  1  one-cycle pulse when a frame is dropped after MAX_RETRY retries.
- rx_overflow  out  1  sticky; set when a frame arrives with the RX FIFO full. Cleared by rst or relock.

Behaviour:
- Reset values: tx=1, tx_ready=1, rx_valid=0, rx_data=0, tx_err=0, rx_overflow=0. FIFOs empty.
  - AUTOBAUD=1: baud_locked=0, baud_size=0, state CAL_WAIT.
  - AUTOBAUD=0: baud_locked=1, baud_size=DEFAULT_BAUD, state IDLE.
- FIFO handshakes:
  - Push when tx_valid&tx_ready. Pop when rx_valid&rx_ready.
  - A push and a pop on the same FIFO in the same cycle are both honoured; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - rx_data is the registered head entry; no read latency beyond that.
- Calibration:
  - CAL_WAIT -> CAL_COUNT on rx=0; counter starts at 1 and increments each cycle rx=0, saturating at all-ones.
  - On rx=1: baud_size<=count, baud_locked<=1, then CAL_ACK drives tx=0 for exactly baud_size clocks, then IDLE.
  - A measured count below 2 is rejected: return to CAL_WAIT, no ack.
- Half-baud is baud_size>>1 (floor).
- IDLE priority: rx=0 (RX start) beats a non-empty TX FIFO in the same cycle.
- RX path:
  - RX_START: wait half-baud; if rx=1 at mid-bit, the start was a glitch -> IDLE.
  - RX_BITS: sample every baud_size clocks at mid-bit, DATA_WIDTH samples, LSB first.
  - RX_STOP: sample the stop bit.
    - Stop=1 and FIFO not full: push the frame, then RX_ACK drives tx=0 for baud_size clocks, then IDLE.
    - Stop=0 (framing error): no push, no ack; wait for rx=1, then IDLE.
    - FIFO full: set rx_overflow, no ack, frame discarded.
- TX path:
  - TX_FRAME takes the head of the TX FIFO without popping it.
  - Sends 1 start bit (0), DATA_WIDTH bits LSB first, 1 stop bit (1); each bit lasts exactly baud_size clocks.
  - TX_ACK_WAIT: watch for rx=0 within ACK_TIMEOUT*baud_size clocks. The ack is accepted once rx returns high; then pop, clear the retry count, go to IDLE.
  - On timeout: if retry<MAX_RETRY, increment retry and resend the same frame after one idle bit-time. Otherwise pop, pulse tx_err, go to IDLE.
- relock:
  - Honoured only in IDLE or CAL_WAIT; held pending otherwise, so any frame in flight completes.
  - Action: baud_locked<=0, rx_overflow<=0, go to CAL_WAIT. FIFO contents are kept.
- No TX is started while baud_locked=0. rx frames arriving while unlocked are treated as calibration pulses.
- rst mid-frame: immediate return to reset values; tx=1 the next cycle.

Test Plan:
- Calibration: AUTOBAUD=1, hold rx=0 for 12 clocks -> baud_size=12, baud_locked=1; tx low for exactly 12 clocks starting 1 cycle after rx rises.
- RX frame: baud 12, send 10'h2A5 LSB first with valid stop -> rx_valid=1, rx_data=10'h2A5; tx ack low for 12 clocks.
- TX with ack: push 10'h155 -> tx waveform start,1,0,1,0,1,0,1,0,1,0,stop at 12 clocks/bit; ack pulse on rx -> tx_ready=1, FIFO empty, no tx_err.
- Retry/drop: MAX_RETRY=2, never ack -> frame sent 3 times; tx_err pulses once; the next queued frame is then sent.
- Overflow: FIFO_DEPTH=4, 5 frames received with rx_ready=0 -> 4 stored, rx_overflow=1, no ack for frame 5; relock clears the flag.
- Collision and glitch: RX start and TX push in the same cycle -> RX completes first, then TX. A 3-clock low glitch -> IDLE, no push.

Source files
------------

// File: rtl/ext_serial_link.sv
// Half-duplex auto-baud serial link: TX/RX FIFOs, per-frame acknowledge pulses,
// ack timeout with bounded retry, and sticky RX overflow.
module ext_serial_link #(
    parameter int DATA_WIDTH   = 10,
    parameter int FIFO_DEPTH   = 4,
    parameter int BAUD_W       = 16,
    parameter int DEFAULT_BAUD = 8,
    parameter int AUTOBAUD     = 1,
    parameter int ACK_TIMEOUT  = 4,
    parameter int MAX_RETRY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  tx,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic                  relock,
    output logic                  baud_locked,
    output logic [BAUD_W-1:0]     baud_size,
    output logic                  tx_err,
    output logic                  rx_overflow
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int BW = $clog2(DATA_WIDTH + 2);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    localparam logic [CW-1:0] CNT_FULL     = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_RX_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_TX_BIT  = BW'(DATA_WIDTH + 1);
    localparam logic [AW-1:0] ACK_LAST     = AW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);
    localparam logic [BAUD_W-1:0] MIN_BAUD = BAUD_W'(2);

    typedef enum logic [3:0] {
        CAL_WAIT, CAL_COUNT, CAL_ACK, IDLE,
        RX_START, RX_BITS, RX_STOP, RX_WAIT_HIGH, RX_ACK,
        TX_FRAME, TX_ACK_WAIT, TX_ACK_HIGH, TX_GAP
    } state_t;

    state_t state;

    logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0]         tx_wr, tx_rd, rx_wr, rx_rd;
    logic [CW-1:0]         tx_cnt, rx_cnt;

    logic [BAUD_W-1:0]     timer, cal_cnt, half_baud;
    logic [BW-1:0]         rx_bit, tx_bit;
    logic [AW-1:0]         ack_bits;
    logic [RW-1:0]         retry;
    logic [DATA_WIDTH-1:0] rx_shift, tx_shift, tx_head;
    logic [DATA_WIDTH:0]   rx_cat, tx_cat;
    logic                  relock_pend, relock_now, bit_tick;
    logic                  tx_push, tx_pop, rx_push, rx_pop, rx_full;

    assign tx_ready   = (tx_cnt != CNT_FULL);
    assign rx_valid   = (rx_cnt != '0);
    assign rx_full    = (rx_cnt == CNT_FULL);
    assign rx_data    = rx_mem[rx_rd];
    assign tx_head    = tx_mem[tx_rd];
    assign tx_push    = tx_valid && tx_ready;
    assign rx_pop     = rx_valid && rx_ready;
    assign half_baud  = baud_size >> 1;
    assign bit_tick   = (timer == '0);
    assign relock_now = relock || relock_pend;
    assign rx_cat     = {rx, rx_shift};
    assign tx_cat     = {1'b1, tx_shift};

    // A frame leaves the TX FIFO only once it is acknowledged or finally dropped.
    assign tx_pop  = ((state == TX_ACK_HIGH) && rx) ||
                     ((state == TX_ACK_WAIT) && rx && bit_tick &&
                      (ack_bits == ACK_LAST) && (retry == RETRY_MAX));
    assign rx_push = (state == RX_STOP) && bit_tick && rx && !rx_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tx_mem[i] <= '0;
                rx_mem[i] <= '0;
            end
        end else begin
            if (tx_push) begin
                tx_mem[tx_wr] <= tx_data;
                tx_wr         <= tx_wr + 1'b1;
            end
            if (tx_pop)
                tx_rd <= tx_rd + 1'b1;
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            if (rx_push) begin
                rx_mem[rx_wr] <= rx_shift;
                rx_wr         <= rx_wr + 1'b1;
            end
            if (rx_pop)
                rx_rd <= rx_rd + 1'b1;
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= (AUTOBAUD != 0) ? CAL_WAIT : IDLE;
            baud_size   <= BAUD_W'((AUTOBAUD != 0) ? 0 : DEFAULT_BAUD);
            baud_locked <= (AUTOBAUD == 0);
            tx          <= 1'b1;
            tx_err      <= 1'b0;
            rx_overflow <= 1'b0;
            relock_pend <= 1'b0;
            timer       <= '0;
            cal_cnt     <= '0;
            rx_bit      <= '0;
            tx_bit      <= '0;
            ack_bits    <= '0;
            retry       <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
        end else begin
            tx_err <= 1'b0;
            if (relock)
                relock_pend <= 1'b1;
            if (!bit_tick)
                timer <= timer - 1'b1;

            case (state)
                CAL_WAIT: begin
                    if (relock_now) begin
                        relock_pend <= 1'b0;
                        baud_locked <= 1'b0;
                        rx_overflow <= 1'b0;
                    end
                    if (!rx) begin
                        cal_cnt <= BAUD_W'(1);
                        state   <= CAL_COUNT;
                    end
                end
                CAL_COUNT: begin
                    if (!rx) begin
                        if (cal_cnt != '1)
                            cal_cnt <= cal_cnt + 1'b1;
                    end else if (cal_cnt < MIN_BAUD) begin
                        state <= CAL_WAIT;
                    end else begin
                        baud_size   <= cal_cnt;
                        baud_locked <= 1'b1;
                        timer       <= cal_cnt - 1'b1;
                        tx          <= 1'b0;
                        state       <= CAL_ACK;
                    end
                end
                CAL_ACK, RX_ACK: begin
                    if (bit_tick) begin
                        tx    <= 1'b1;
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (relock_now) begin
                        relock_pend <= 1'b0;
                        baud_locked <= 1'b0;
                        rx_overflow <= 1'b0;
                        state       <= CAL_WAIT;
                    end else if (!rx) begin
                        timer <= half_baud - 1'b1;
                        state <= RX_START;
                    end else if (tx_cnt != '0) begin
                        tx_shift <= tx_head;
                        tx       <= 1'b0;
                        tx_bit   <= '0;
                        timer    <= baud_size - 1'b1;
                        state    <= TX_FRAME;
                    end
                end
                RX_START: begin
                    if (bit_tick) begin
                        if (rx) begin
                            state <= IDLE;
                        end else begin
                            timer  <= baud_size - 1'b1;
                            rx_bit <= '0;
                            state  <= RX_BITS;
                        end
                    end
                end
                RX_BITS: begin
                    if (bit_tick) begin
                        rx_shift <= rx_cat[DATA_WIDTH:1];
                        timer    <= baud_size - 1'b1;
                        if (rx_bit == LAST_RX_BIT)
                            state <= RX_STOP;
                        else
                            rx_bit <= rx_bit + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_tick) begin
                        if (!rx) begin
                            state <= RX_WAIT_HIGH;
                        end else if (rx_full) begin
                            rx_overflow <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            tx    <= 1'b0;
                            timer <= baud_size - 1'b1;
                            state <= RX_ACK;
                        end
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx)
                        state <= IDLE;
                end
                // tx_bit counts finished bit periods: start, data, then stop.
                TX_FRAME: begin
                    if (bit_tick) begin
                        timer <= baud_size - 1'b1;
                        if (tx_bit == LAST_TX_BIT) begin
                            ack_bits <= '0;
                            state    <= TX_ACK_WAIT;
                        end else begin
                            tx       <= tx_shift[0];
                            tx_shift <= tx_cat[DATA_WIDTH:1];
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end
                end
                TX_ACK_WAIT: begin
                    if (!rx) begin
                        state <= TX_ACK_HIGH;
                    end else if (bit_tick) begin
                        timer <= baud_size - 1'b1;
                        if (ack_bits != ACK_LAST) begin
                            ack_bits <= ack_bits + 1'b1;
                        end else if (retry == RETRY_MAX) begin
                            retry  <= '0;
                            tx_err <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            retry <= retry + 1'b1;
                            state <= TX_GAP;
                        end
                    end
                end
                TX_ACK_HIGH: begin
                    if (rx) begin
                        retry <= '0;
                        state <= IDLE;
                    end
                end
                TX_GAP: begin
                    if (bit_tick) begin
                        tx_shift <= tx_head;
                        tx       <= 1'b0;
                        tx_bit   <= '0;
                        timer    <= baud_size - 1'b1;
                        state    <= TX_FRAME;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
